// File: rtl/fir_iq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_iq_pkg
//  Description : Shared constants, FSM state encoding and coefficient
//                half-tables for the I/Q interpolate-by-2 FIR.
//  Revision    : 1.0  initial release
// ============================================================================
package fir_iq_pkg;

    localparam int NTAPS  = 33;
    localparam int COEFF  = 18;
    localparam int HALF   = (NTAPS + 1) / 2;
    localparam int IDX_W  = $clog2(HALF);
    localparam int KW     = $clog2(NTAPS);
    localparam int RX_CFG = 0;

    typedef logic signed [COEFF-1:0] coeff_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        MAC0  = 3'd2,
        OUT0  = 3'd3,
        MAC1  = 3'd4,
        OUT1  = 3'd5
    } state_t;

    // Half table entry m (0..HALF-1). Both tables keep the even-tap sum and
    // the odd-tap sum at exactly 2^17, so each polyphase branch has unity DC gain.
    function automatic coeff_t half_tap(input logic [KW-1:0] m);
        coeff_t t;
        t = '0;
        if (RX_CFG == 0) begin
            case (m)
                6'd0:    t = -18'sd64;
                6'd1:    t = -18'sd128;
                6'd2:    t = -18'sd160;
                6'd3:    t = -18'sd96;
                6'd4:    t =  18'sd128;
                6'd5:    t =  18'sd512;
                6'd6:    t =  18'sd1024;
                6'd7:    t =  18'sd1600;
                6'd8:    t =  18'sd2800;
                6'd9:    t =  18'sd4000;
                6'd10:   t =  18'sd6000;
                6'd11:   t =  18'sd8000;
                6'd12:   t =  18'sd11000;
                6'd13:   t =  18'sd14000;
                6'd14:   t =  18'sd25000;
                6'd15:   t =  18'sd37648;
                6'd16:   t =  18'sd39616;
                default: t = '0;
            endcase
        end else begin
            case (m)
                6'd9:    t = -18'sd2048;
                6'd10:   t = -18'sd1024;
                6'd11:   t =  18'sd4096;
                6'd12:   t =  18'sd2048;
                6'd13:   t =  18'sd16384;
                6'd14:   t =  18'sd20480;
                6'd15:   t =  18'sd47104;
                6'd16:   t =  18'sd88064;
                default: t = '0;
            endcase
        end
        return t;
    endfunction

    // Full prototype coefficient h[k], mirrored about the centre tap.
    function automatic coeff_t coeff_at(input logic [KW-1:0] k);
        logic [KW-1:0] mirror;
        mirror = KW'(NTAPS - 1) - k;
        if (k < KW'(HALF)) return half_tap(k);
        else               return half_tap(mirror);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_iq_interp2_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_iq_interp2_if
//  Description : Sample strobe/data bus and status flags of the I/Q
//                interpolate-by-2 FIR. master = sample source, slave = filter.
//  Revision    : 1.0  initial release
// ============================================================================
interface fir_iq_interp2_if #(
    parameter int WIDTH = 24
);
    logic                    in_strobe;
    logic signed [WIDTH-1:0] in_data_i;
    logic signed [WIDTH-1:0] in_data_q;
    logic                    out_strobe;
    logic signed [WIDTH-1:0] out_data_i;
    logic signed [WIDTH-1:0] out_data_q;
    logic                    busy;
    logic                    overrun;

    modport master (
        output in_strobe, in_data_i, in_data_q,
        input  out_strobe, out_data_i, out_data_q, busy, overrun
    );

    modport slave (
        input  in_strobe, in_data_i, in_data_q,
        output out_strobe, out_data_i, out_data_q, busy, overrun
    );
endinterface
`default_nettype wire

// File: rtl/fir_mac_sat.sv
`default_nettype none
// ============================================================================
//  Module      : fir_mac_sat
//  Description : Signed multiply-accumulate with synchronous clear and a
//                saturating output slice (acc >>> (COEFF-1) clamped to WIDTH).
//  Revision    : 1.0  initial release
// ============================================================================
module fir_mac_sat #(
    parameter int WIDTH = 24,
    parameter int COEFF = 18
) (
    input  wire logic                    adc_clk,
    input  wire logic                    reset,
    input  wire logic                    clear,
    input  wire logic                    accumulate,
    input  wire logic signed [WIDTH-1:0] sample,
    input  wire logic signed [COEFF-1:0] coeff,
    output logic signed [WIDTH-1:0]      result
);
    localparam int AW = WIDTH + COEFF + 1;
    localparam int PW = WIDTH + COEFF;

    logic signed [AW-1:0] r_acc;
    logic signed [PW-1:0] w_prod;
    logic signed [AW-1:0] w_shift;

    assign w_prod = sample * coeff;

    // Accumulator: clear wins over accumulate so a new phase starts from zero.
    always_ff @(posedge adc_clk) begin
        if (reset || clear) begin
            r_acc <= '0;
        end else if (accumulate) begin
            r_acc <= r_acc + {w_prod[PW-1], w_prod};
        end
    end

    // Drop the Q1.17 fraction (keeping the x2 tap gain) and clamp to WIDTH.
    always_comb begin
        w_shift = r_acc >>> (COEFF - 1);
        if (w_shift[AW-1:WIDTH-1] == {(AW-WIDTH+1){w_shift[WIDTH-1]}}) begin
            result = w_shift[WIDTH-1:0];
        end else if (w_shift[AW-1]) begin
            result = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            result = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
endmodule
`default_nettype wire

// File: rtl/fir_iq_interp2.sv
`default_nettype none
// ============================================================================
//  Module      : fir_iq_interp2
//  Description : Interpolate-by-2 complex FIR. Each accepted input produces
//                the phase-0 then the phase-1 polyphase output, computed by
//                one time-shared MAC per channel under a small FSM.
//  Revision    : 1.0  initial release
// ============================================================================
module fir_iq_interp2
    import fir_iq_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  wire logic        adc_clk,
    input  wire logic        reset,
    fir_iq_interp2_if.slave  bus
);
    localparam logic [IDX_W-1:0] LAST0 = IDX_W'(HALF - 1);
    localparam logic [IDX_W-1:0] LAST1 = IDX_W'(HALF - 2);

    state_t                  state;
    state_t                  next_state;
    logic [IDX_W-1:0]        r_j;
    logic signed [WIDTH-1:0] dl_i [HALF];
    logic signed [WIDTH-1:0] dl_q [HALF];

    logic                    w_mac_clear;
    logic                    w_mac_acc;
    logic                    w_load;
    logic                    w_j_clear;
    logic                    w_j_inc;
    logic [KW-1:0]           w_k;
    coeff_t                  w_coeff;
    logic signed [WIDTH-1:0] w_res_i;
    logic signed [WIDTH-1:0] w_res_q;

    // Phase 0 walks the even taps, phase 1 the odd taps: k = 2j + phase.
    assign w_k      = {r_j, (state == MAC1)};
    assign w_coeff  = coeff_at(w_k);
    assign bus.busy = (state != IDLE);

    // State register.
    always_ff @(posedge adc_clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state and datapath control.
    always_comb begin
        next_state  = state;
        w_mac_clear = 1'b0;
        w_mac_acc   = 1'b0;
        w_load      = 1'b0;
        w_j_clear   = 1'b0;
        w_j_inc     = 1'b0;
        case (state)
            IDLE:  if (bus.in_strobe) next_state = LATCH;
            LATCH: begin
                w_mac_clear = 1'b1;
                w_j_clear   = 1'b1;
                next_state  = MAC0;
            end
            MAC0:  begin
                w_mac_acc = 1'b1;
                w_j_inc   = 1'b1;
                if (r_j == LAST0) next_state = OUT0;
            end
            OUT0:  begin
                w_load      = 1'b1;
                w_mac_clear = 1'b1;
                w_j_clear   = 1'b1;
                next_state  = MAC1;
            end
            MAC1:  begin
                w_mac_acc = 1'b1;
                w_j_inc   = 1'b1;
                if (r_j == LAST1) next_state = OUT1;
            end
            OUT1:  begin
                w_load     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Tap index shared by both channels.
    always_ff @(posedge adc_clk) begin
        if (reset || w_j_clear) r_j <= '0;
        else if (w_j_inc)       r_j <= r_j + IDX_W'(1);
    end

    // Delay line: shifts only when a strobe is accepted in IDLE.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            for (int n = 0; n < HALF; n++) begin
                dl_i[n] <= '0;
                dl_q[n] <= '0;
            end
        end else if (state == IDLE && bus.in_strobe) begin
            dl_i[0] <= bus.in_data_i;
            dl_q[0] <= bus.in_data_q;
            for (int n = 1; n < HALF; n++) begin
                dl_i[n] <= dl_i[n-1];
                dl_q[n] <= dl_q[n-1];
            end
        end
    end

    fir_mac_sat #(.WIDTH(WIDTH), .COEFF(COEFF)) u_mac_i (
        .adc_clk    (adc_clk),
        .reset      (reset),
        .clear      (w_mac_clear),
        .accumulate (w_mac_acc),
        .sample     (dl_i[r_j]),
        .coeff      (w_coeff),
        .result     (w_res_i)
    );

    fir_mac_sat #(.WIDTH(WIDTH), .COEFF(COEFF)) u_mac_q (
        .adc_clk    (adc_clk),
        .reset      (reset),
        .clear      (w_mac_clear),
        .accumulate (w_mac_acc),
        .sample     (dl_q[r_j]),
        .coeff      (w_coeff),
        .result     (w_res_q)
    );

    // Output registers, strobe and overrun flag; data holds between strobes.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            bus.out_strobe <= 1'b0;
            bus.out_data_i <= '0;
            bus.out_data_q <= '0;
            bus.overrun    <= 1'b0;
        end else begin
            bus.out_strobe <= w_load;
            bus.overrun    <= bus.in_strobe && (state != IDLE);
            if (w_load) begin
                bus.out_data_i <= w_res_i;
                bus.out_data_q <= w_res_q;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fir_iq_interp2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_iq_interp2
//  Description : Scoreboard bench for fir_iq_interp2: directed impulse, DC,
//                saturation, overrun, back-to-back and mid-operation reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_iq_interp2;
    localparam int W = 24;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;

    fir_iq_interp2_if #(.WIDTH(W)) bus ();

    fir_iq_interp2 #(.WIDTH(W)) dut (
        .adc_clk (clk),
        .reset   (reset),
        .bus     (bus)
    );

    typedef struct {
        int ei;
        int eq;
        int tol;
        int id;
    } exp_t;

    exp_t sb[$];
    int   out_cyc[$];
    int   ov_cyc[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   out_cnt      = 0;
    int   ov_cnt       = 0;
    int   seq          = 0;
    exp_t mon_e;

    // Prototype h[0..32], Q1.17, written out in full.
    int hb [33] = '{-64, -128, -160, -96, 128, 512, 1024, 1600, 2800, 4000,
                    6000, 8000, 11000, 14000, 25000, 37648, 39616, 37648,
                    25000, 14000, 11000, 8000, 6000, 4000, 2800, 1600, 1024,
                    512, 128, -96, -160, -128, -64};
    int mdl_i [17];
    int mdl_q [17];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp, input int tol);
        tests_run++;
        if (act > exp + tol || act < exp - tol) begin
            tests_failed++;
            $display("FAIL %s: got %0d, required %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
        end
    endtask

    function automatic int model_out(input int ph, input bit use_q);
        longint acc = 0;
        longint r;
        int last = (ph == 0) ? 16 : 15;
        for (int j = 0; j <= last; j++)
            acc += longint'(use_q ? mdl_q[j] : mdl_i[j]) * longint'(hb[2*j + ph]);
        r = acc >>> 17;
        if (r > 64'sd8388607)  r = 64'sd8388607;
        if (r < -64'sd8388608) r = -64'sd8388608;
        return int'(r);
    endfunction

    // Monitor: pops one expectation per out_strobe, logs strobe/overrun cycles.
    always @(negedge clk) begin
        if (bus.overrun) begin
            ov_cnt++;
            ov_cyc.push_back(cyc);
        end
        if (bus.out_strobe) begin
            out_cnt++;
            out_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL unexpected_out: got strobe I=%0d Q=%0d at cycle %0d, required none",
                         int'(bus.out_data_i), int'(bus.out_data_q), cyc);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("out%0d_I", mon_e.id), int'(bus.out_data_i), mon_e.ei, mon_e.tol);
                check($sformatf("out%0d_Q", mon_e.id), int'(bus.out_data_q), mon_e.eq, mon_e.tol);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int ei, input int eq, input int tol);
        exp_t e;
        e.ei  = ei;
        e.eq  = eq;
        e.tol = tol;
        e.id  = seq;
        seq++;
        sb.push_back(e);
    endtask

    // One input strobe; hand=1 pushes the given values, else the model result.
    task automatic send(input int di, input int dq, input bit hand,
                        input int h0i, input int h0q, input int h1i, input int h1q,
                        input int tol);
        bus.in_data_i = W'(di);
        bus.in_data_q = W'(dq);
        bus.in_strobe = 1'b1;
        for (int n = 16; n > 0; n--) begin
            mdl_i[n] = mdl_i[n-1];
            mdl_q[n] = mdl_q[n-1];
        end
        mdl_i[0] = di;
        mdl_q[0] = dq;
        if (hand) begin
            push_exp(h0i, h0q, tol);
            push_exp(h1i, h1q, tol);
        end else begin
            push_exp(model_out(0, 1'b0), model_out(0, 1'b1), 0);
            push_exp(model_out(1, 1'b0), model_out(1, 1'b1), 0);
        end
        tick(1);
        bus.in_strobe = 1'b0;
    endtask

    task automatic clear_model();
        for (int n = 0; n < 17; n++) begin
            mdl_i[n] = 0;
            mdl_q[n] = 0;
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_strobe = 1'b0;
        tick(2);
        reset = 1'b0;
        clear_model();
        sb.delete();
        out_cyc.delete();
        ov_cyc.delete();
    endtask

    // Unit impulse of 2^20: outputs are exactly 8*h[0], 8*h[1], ..., 8*h[32], 0.
    task automatic run_impulse(input string tag);
        int base;
        base = out_cnt;
        for (int n = 0; n < 17; n++) begin
            send((n == 0) ? 1048576 : 0, 0, 1'b1,
                 8 * hb[2*n], 0, (n < 16) ? 8 * hb[2*n + 1] : 0, 0, 0);
            tick(39);
        end
        check({tag, "_count"}, out_cnt - base, 34, 0);
        check({tag, "_pending"}, sb.size(), 0, 0);
    endtask

    // Continuous input at exactly the minimum spacing; settled outputs hand-checked.
    task automatic run_stream(input string tag, input int di, input int dq,
                              input int tol);
        int base_out;
        int base_ov;
        base_out = out_cnt;
        base_ov  = ov_cnt;
        for (int n = 0; n < 20; n++) begin
            if (n >= 16) send(di, dq, 1'b1, di, dq, di, dq, tol);
            else         send(di, dq, 1'b0, 0, 0, 0, 0, 0);
            tick(36);
        end
        tick(4);
        check({tag, "_count"}, out_cnt - base_out, 40, 0);
        check({tag, "_overruns"}, ov_cnt - base_ov, 0, 0);
        check({tag, "_pending"}, sb.size(), 0, 0);
    endtask

    initial begin
        int t;
        reset          = 1'b1;
        bus.in_strobe  = 1'b0;
        bus.in_data_i  = '0;
        bus.in_data_q  = '0;
        clear_model();
        tick(3);
        reset = 1'b0;

        check("rst_out_strobe", int'(bus.out_strobe), 0, 0);
        check("rst_out_data_i", int'(bus.out_data_i), 0, 0);
        check("rst_out_data_q", int'(bus.out_data_q), 0, 0);
        check("rst_busy",       int'(bus.busy), 0, 0);
        check("rst_overrun",    int'(bus.overrun), 0, 0);

        run_impulse("impulse");

        do_reset();
        run_stream("dc", 4194304, 4194304, 8192);

        do_reset();
        run_stream("sat", 8388607, -8388608, 0);

        // Overrun: a second strobe at t+10 is dropped, timing is unaffected.
        do_reset();
        t = cyc;
        send(2097152, -1048576, 1'b0, 0, 0, 0, 0, 0);
        tick(9);
        bus.in_data_i = 24'h7FFFFF;
        bus.in_data_q = 24'h7FFFFF;
        bus.in_strobe = 1'b1;
        tick(1);
        bus.in_strobe = 1'b0;
        check("ovr_pulse_t11", int'(bus.overrun), 1, 0);
        check("ovr_busy_t11",  int'(bus.busy), 1, 0);
        tick(25);
        check("ovr_busy_t36",  int'(bus.busy), 1, 0);
        tick(1);
        check("ovr_busy_t37",  int'(bus.busy), 0, 0);
        tick(3);
        check("ovr_pulses",    ov_cyc.size(), 1, 0);
        check("ovr_cycle",     (ov_cyc.size() > 0) ? ov_cyc[0] - t : -1, 11, 0);
        check("ovr_out_count", out_cyc.size(), 2, 0);
        check("ovr_out0_cyc",  (out_cyc.size() > 0) ? out_cyc[0] - t : -1, 20, 0);
        check("ovr_out1_cyc",  (out_cyc.size() > 1) ? out_cyc[1] - t : -1, 37, 0);
        // The dropped sample must not have entered the delay line.
        send(0, 0, 1'b0, 0, 0, 0, 0, 0);
        tick(40);
        check("ovr_pending", sb.size(), 0, 0);

        // Reset during MAC1: phase 1 is discarded and the delay line cleared.
        do_reset();
        t = cyc;
        send(1048576, 0, 1'b1, 8 * hb[0], 0, 8 * hb[1], 0, 0);
        tick(24);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rst_mid_busy_t26", int'(bus.busy), 0, 0);
        check("rst_mid_strobe_t26", int'(bus.out_strobe), 0, 0);
        check("rst_mid_pending", sb.size(), 1, 0);
        sb.delete();
        clear_model();
        tick(14);
        check("rst_mid_out_count", out_cyc.size(), 1, 0);
        check("rst_mid_out0_cyc", (out_cyc.size() > 0) ? out_cyc[0] - t : -1, 20, 0);
        run_impulse("impulse_after_rst");

        check("final_pending", sb.size(), 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
